// File: rtl/tube_pkg.sv
// Shared constants for the parasite-side tube front end: ctrl flag bit
// positions, address field layout and the access FSM encoding.
package tube_pkg;

    localparam int FLAG_S = 7;
    localparam int FLAG_T = 6;
    localparam int FLAG_P = 5;
    localparam int FLAG_V = 4;
    localparam int FLAG_M = 3;
    localparam int FLAG_J = 2;
    localparam int FLAG_I = 1;
    localparam int FLAG_Q = 0;

    localparam int DATA_BIT = 0;
    localparam int IDX_MSB  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/p_irq_gen.sv
// Registered parasite IRQ/NMI generation from host control flags and FIFO
// status; outputs are active-low and update one cycle after their inputs.
module p_irq_gen (
    input  logic p_phi2,
    input  logic h_rst_b,
    input  logic flag_i,
    input  logic flag_j,
    input  logic flag_m,
    input  logic flag_v,
    input  logic hp_avail0,
    input  logic hp_avail2,
    input  logic hp_avail3,
    input  logic hp_r3_two_bytes,
    input  logic ph_r3_empty,
    output logic p_irq_b,
    output logic p_nmi_b
);

    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            p_irq_b <= 1'b1;
            p_nmi_b <= 1'b1;
        end else begin
            p_irq_b <= ~((flag_i & hp_avail0) | (flag_j & hp_avail3));
            // V selects whether R3 NMI waits for a two-byte transfer or any data
            p_nmi_b <= ~((flag_m & (flag_v ? hp_r3_two_bytes : hp_avail2)) |
                         (flag_m & ph_r3_empty));
        end
    end

endmodule

// File: rtl/p_regif.sv
// Parasite bus front end: one FIFO strobe per chip-select assertion, read data
// latch, per-register status bytes and the interrupt outputs.
//
//   state     | meaning
//   ST_IDLE   | waiting for cs low; captures address, direction and write data
//   ST_ACCESS | single strobe cycle; read data / status latched on its closing edge
//   ST_HOLD   | cs still low after the access; drive bus on reads, wait for cs high
module p_regif
    import tube_pkg::*;
#(
    parameter int NUM_REGS = 2 ** IDX_MSB
) (
    input  logic                                 p_phi2,
    input  logic                                 h_rst_b,
    input  logic                                 p_cs_b,
    input  logic                                 p_rdnw,
    input  logic [$clog2(2*NUM_REGS)-1:0]        p_addr,
    input  logic [7:0]                           p_data_in,
    input  logic [7:0]                           hp_data,
    input  logic [NUM_REGS-1:0]                  hp_avail,
    input  logic                                 hp_r3_two_bytes,
    input  logic [NUM_REGS-1:0]                  ph_not_full,
    input  logic                                 ph_r3_empty,
    input  logic [7:0]                           ctrl_flags,
    output logic [NUM_REGS-1:0]                  hp_select,
    output logic                                 hp_rdnw,
    output logic [NUM_REGS-1:0]                  ph_wr_select,
    output logic [7:0]                           ph_wr_data,
    output logic [7:0]                           p_data_out,
    output logic                                 p_data_oe,
    output logic                                 p_irq_b,
    output logic                                 p_nmi_b
);

    localparam int ADDR_W = $clog2(2 * NUM_REGS);
    localparam int IDX_W  = ADDR_W - 1;

    state_t              state;
    logic                rdnw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [IDX_W-1:0]    idx_in;
    logic [IDX_W-1:0]    idx_q;
    logic [NUM_REGS-1:0] sel_new;
    logic [7:0]          status_byte;
    logic                unused_flags;

    assign idx_in  = p_addr[ADDR_W-1:DATA_BIT+1];
    assign idx_q   = addr_q[ADDR_W-1:DATA_BIT+1];
    assign sel_new = NUM_REGS'(1) << idx_in;

    // Only register 0 carries the host control flags in its status byte
    assign status_byte = {hp_avail[idx_q], ph_not_full[idx_q],
                          (idx_q == '0) ? ctrl_flags[FLAG_P:FLAG_Q] : 6'b0};

    // The read side only ever pops, so the qualifier is permanently read
    assign hp_rdnw = 1'b1;

    assign unused_flags = ^ctrl_flags[FLAG_S:FLAG_T];

    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state        <= ST_IDLE;
            rdnw_q       <= 1'b1;
            addr_q       <= '0;
            hp_select    <= '0;
            ph_wr_select <= '0;
            ph_wr_data   <= 8'h00;
            p_data_out   <= 8'h00;
            p_data_oe    <= 1'b0;
        end else begin
            hp_select    <= '0;
            ph_wr_select <= '0;
            case (state)
                ST_IDLE: begin
                    if (!p_cs_b) begin
                        addr_q     <= p_addr;
                        rdnw_q     <= p_rdnw;
                        ph_wr_data <= p_data_in;
                        state      <= ST_ACCESS;
                        if (p_addr[DATA_BIT]) begin
                            if (p_rdnw) hp_select    <= sel_new;
                            else        ph_wr_select <= sel_new;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (rdnw_q) begin
                        p_data_out <= addr_q[DATA_BIT] ? hp_data : status_byte;
                    end
                    if (!p_cs_b) begin
                        state     <= ST_HOLD;
                        p_data_oe <= rdnw_q;
                    end else begin
                        state     <= ST_IDLE;
                        p_data_oe <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (p_cs_b) begin
                        state     <= ST_IDLE;
                        p_data_oe <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    p_data_oe <= 1'b0;
                end
            endcase
        end
    end

    p_irq_gen u_irq_gen (
        .p_phi2          (p_phi2),
        .h_rst_b         (h_rst_b),
        .flag_i          (ctrl_flags[FLAG_I]),
        .flag_j          (ctrl_flags[FLAG_J]),
        .flag_m          (ctrl_flags[FLAG_M]),
        .flag_v          (ctrl_flags[FLAG_V]),
        .hp_avail0       (hp_avail[0]),
        .hp_avail2       (hp_avail[2]),
        .hp_avail3       (hp_avail[3]),
        .hp_r3_two_bytes (hp_r3_two_bytes),
        .ph_r3_empty     (ph_r3_empty),
        .p_irq_b         (p_irq_b),
        .p_nmi_b         (p_nmi_b)
    );

endmodule

// File: tb/tb_p_regif.sv
// Self-checking bench for p_regif: table of single accesses with a read-data
// scoreboard, plus hand sequences for long cs, interrupts and mid-access reset.
module tb_p_regif;

    logic       p_phi2 = 1'b0;
    logic       h_rst_b;
    logic       p_cs_b;
    logic       p_rdnw;
    logic [2:0] p_addr;
    logic [7:0] p_data_in;
    logic [7:0] hp_data;
    logic [3:0] hp_avail;
    logic       hp_r3_two_bytes;
    logic [3:0] ph_not_full;
    logic       ph_r3_empty;
    logic [7:0] ctrl_flags;
    logic [3:0] hp_select;
    logic       hp_rdnw;
    logic [3:0] ph_wr_select;
    logic [7:0] ph_wr_data;
    logic [7:0] p_data_out;
    logic       p_data_oe;
    logic       p_irq_b;
    logic       p_nmi_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic       rdnw;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] hpd;
        logic [3:0] avail;
        logic [3:0] nfull;
        logic [7:0] flags;
        logic [3:0] e_hp;
        logic [3:0] e_ph;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[10];

    always #5 p_phi2 = ~p_phi2;

    p_regif dut (
        .p_phi2          (p_phi2),
        .h_rst_b         (h_rst_b),
        .p_cs_b          (p_cs_b),
        .p_rdnw          (p_rdnw),
        .p_addr          (p_addr),
        .p_data_in       (p_data_in),
        .hp_data         (hp_data),
        .hp_avail        (hp_avail),
        .hp_r3_two_bytes (hp_r3_two_bytes),
        .ph_not_full     (ph_not_full),
        .ph_r3_empty     (ph_r3_empty),
        .ctrl_flags      (ctrl_flags),
        .hp_select       (hp_select),
        .hp_rdnw         (hp_rdnw),
        .ph_wr_select    (ph_wr_select),
        .ph_wr_data      (ph_wr_data),
        .p_data_out      (p_data_out),
        .p_data_oe       (p_data_oe),
        .p_irq_b         (p_irq_b),
        .p_nmi_b         (p_nmi_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_phi2);
        #1;
    endtask

    task automatic sb_check(input string name);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            check({name, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(name, {24'd0, p_data_out}, {24'd0, e});
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", i);
        p_rdnw      = v.rdnw;
        p_addr      = v.addr;
        p_data_in   = v.wdata;
        hp_data     = v.hpd;
        hp_avail    = v.avail;
        ph_not_full = v.nfull;
        ctrl_flags  = v.flags;
        p_cs_b      = 1'b0;
        tick();
        check({tag, " hp_select"}, {28'd0, hp_select}, {28'd0, v.e_hp});
        check({tag, " ph_wr_select"}, {28'd0, ph_wr_select}, {28'd0, v.e_ph});
        check({tag, " ph_wr_data"}, {24'd0, ph_wr_data}, {24'd0, v.wdata});
        sb_q.push_back(v.e_dout);
        tick();
        check({tag, " strobe_off"}, {24'd0, hp_select, ph_wr_select}, 32'd0);
        check({tag, " oe_hold"}, {31'd0, p_data_oe}, {31'd0, v.rdnw});
        sb_check({tag, " p_data_out"});
        tick();
        check({tag, " strobe_hold"}, {24'd0, hp_select, ph_wr_select}, 32'd0);
        p_cs_b = 1'b1;
        tick();
        check({tag, " oe_release"}, {31'd0, p_data_oe}, 32'd0);
        tick();
    endtask

    initial begin
        int sel_cnt;

        vecs[0] = '{1'b1, 3'd1, 8'h00, 8'h5A, 4'b0001, 4'b1111, 8'h00, 4'b0001, 4'b0000, 8'h5A};
        vecs[1] = '{1'b1, 3'd5, 8'h00, 8'hC3, 4'b0100, 4'b1111, 8'h00, 4'b0100, 4'b0000, 8'hC3};
        vecs[2] = '{1'b0, 3'd7, 8'h3C, 8'h00, 4'b0000, 4'b1111, 8'h00, 4'b0000, 4'b1000, 8'hC3};
        vecs[3] = '{1'b0, 3'd6, 8'h77, 8'h00, 4'b0000, 4'b1111, 8'h00, 4'b0000, 4'b0000, 8'hC3};
        vecs[4] = '{1'b1, 3'd0, 8'h00, 8'h00, 4'b0001, 4'b0000, 8'h2A, 4'b0000, 4'b0000, 8'hAA};
        vecs[5] = '{1'b1, 3'd4, 8'h00, 8'h00, 4'b0100, 4'b0100, 8'h3F, 4'b0000, 4'b0000, 8'hC0};
        vecs[6] = '{1'b1, 3'd2, 8'h00, 8'h00, 4'b0000, 4'b0010, 8'hFF, 4'b0000, 4'b0000, 8'h40};
        vecs[7] = '{1'b1, 3'd3, 8'h00, 8'h99, 4'b0000, 4'b1111, 8'h00, 4'b0010, 4'b0000, 8'h99};
        vecs[8] = '{1'b0, 3'd1, 8'hE1, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0001, 8'h99};
        vecs[9] = '{1'b0, 3'd0, 8'h55, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h99};

        h_rst_b = 1'b0; p_cs_b = 1'b1; p_rdnw = 1'b1; p_addr = 3'd0; p_data_in = 8'h00;
        hp_data = 8'h00; hp_avail = 4'h0; hp_r3_two_bytes = 1'b0; ph_not_full = 4'h0;
        ph_r3_empty = 1'b0; ctrl_flags = 8'h00;

        // reset held, then released with cs high
        repeat (3) tick();
        check("rst selects", {24'd0, hp_select, ph_wr_select}, 32'd0);
        check("rst hp_rdnw", {31'd0, hp_rdnw}, 32'd1);
        check("rst irq_nmi", {30'd0, p_irq_b, p_nmi_b}, 32'd3);
        check("rst dout_oe", {23'd0, p_data_out, p_data_oe}, 32'd0);
        check("rst wr_data", {24'd0, ph_wr_data}, 32'd0);
        h_rst_b = 1'b1;
        repeat (3) tick();
        check("post_rst selects", {24'd0, hp_select, ph_wr_select}, 32'd0);
        check("post_rst irq_nmi", {30'd0, p_irq_b, p_nmi_b}, 32'd3);
        check("post_rst dout", {24'd0, p_data_out}, 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // long chip select: one strobe only, data held, bus driven until cs rises
        p_rdnw = 1'b1; p_addr = 3'd1; hp_avail = 4'b0001; hp_data = 8'hA5; ctrl_flags = 8'h00;
        p_cs_b = 1'b0;
        sel_cnt = 0;
        sb_q.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (hp_select != 4'b0000) sel_cnt++;
            if (i == 0) check("long hp_select", {28'd0, hp_select}, 32'h1);
            if (i == 1) sb_check("long p_data_out");
            if (i >= 1) check("long oe", {31'd0, p_data_oe}, 32'd1);
        end
        check("long strobe_count", sel_cnt, 32'd1);
        p_cs_b = 1'b1;
        tick();
        check("long oe_release", {31'd0, p_data_oe}, 32'd0);
        check("long dout_held", {24'd0, p_data_out}, 32'hA5);
        tick();

        // interrupts
        ctrl_flags = 8'h00; hp_avail = 4'h0; hp_r3_two_bytes = 1'b0; ph_r3_empty = 1'b0;
        tick(); tick();
        check("irq idle", {30'd0, p_irq_b, p_nmi_b}, 32'd3);
        ctrl_flags = 8'h02;
        tick();
        hp_avail = 4'b0001;
        #1;
        check("irq latency", {31'd0, p_irq_b}, 32'd1);
        tick();
        check("irq I_avail0", {31'd0, p_irq_b}, 32'd0);
        ctrl_flags = 8'h04; hp_avail = 4'b1000;
        tick();
        check("irq J_avail3", {31'd0, p_irq_b}, 32'd0);
        hp_avail = 4'b0000;
        tick();
        check("irq clear", {31'd0, p_irq_b}, 32'd1);
        ctrl_flags = 8'h18; hp_avail = 4'b0100;
        tick();
        check("nmi V_wait", {31'd0, p_nmi_b}, 32'd1);
        tick(); tick();
        check("nmi V_wait2", {31'd0, p_nmi_b}, 32'd1);
        hp_r3_two_bytes = 1'b1;
        tick();
        check("nmi V_two", {31'd0, p_nmi_b}, 32'd0);
        ctrl_flags = 8'h08; hp_r3_two_bytes = 1'b0;
        tick();
        check("nmi M_avail2", {31'd0, p_nmi_b}, 32'd0);
        hp_avail = 4'b0000;
        tick();
        check("nmi clear", {31'd0, p_nmi_b}, 32'd1);
        ph_r3_empty = 1'b1;
        tick();
        check("nmi r3_empty", {31'd0, p_nmi_b}, 32'd0);
        ctrl_flags = 8'h00;
        tick();
        check("nmi M_off", {31'd0, p_nmi_b}, 32'd1);
        ph_r3_empty = 1'b0;

        // reset during ACCESS aborts the strobe; no replay afterwards
        p_rdnw = 1'b1; p_addr = 3'd3; hp_avail = 4'b0010; hp_data = 8'h6E;
        p_cs_b = 1'b0;
        tick();
        check("abort strobe_on", {28'd0, hp_select}, 32'h2);
        h_rst_b = 1'b0;
        #1;
        check("abort strobe_off", {28'd0, hp_select}, 32'd0);
        p_cs_b = 1'b1;
        tick();
        h_rst_b = 1'b1;
        sel_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (hp_select != 4'b0000 || ph_wr_select != 4'b0000) sel_cnt++;
        end
        check("abort no_replay", sel_cnt, 32'd0);
        check("abort dout", {24'd0, p_data_out}, 32'd0);
        p_cs_b = 1'b0;
        tick();
        check("abort fresh_strobe", {28'd0, hp_select}, 32'h2);
        tick();
        check("abort fresh_dout", {24'd0, p_data_out}, 32'h6E);
        p_cs_b = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
